// File: rtl/cdr_reset_ctrl_mc_if.sv
// Status/control bundle between the SERDES receive quad, the per-lane CDR
// reset sequencer and the PCS reset logic.
interface cdr_reset_ctrl_mc_if #(
  parameter int NUM_CH  = 4,
  parameter int RETRY_W = 8
);
  logic [NUM_CH-1:0]         cdr_lol;
  logic [NUM_CH-1:0]         cdr_los;
  logic [NUM_CH-1:0]         force_rst;
  logic                      clr_retry;
  logic [NUM_CH-1:0]         cdr_rst_out;
  logic [NUM_CH-1:0]         lane_locked;
  logic                      all_locked;
  logic [NUM_CH*RETRY_W-1:0] retry_cnt;

  // Side that supplies lane status and requests, and consumes reset/lock.
  modport master (
    output cdr_lol, cdr_los, force_rst, clr_retry,
    input  cdr_rst_out, lane_locked, all_locked, retry_cnt
  );

  // The sequencer itself.
  modport slave (
    input  cdr_lol, cdr_los, force_rst, clr_retry,
    output cdr_rst_out, lane_locked, all_locked, retry_cnt
  );
endinterface

// File: rtl/cdr_reset_ctrl_mc.sv
// Multi-lane CDR reset sequencer. Each lane pulses its CDR reset, waits for
// the CDR to settle, then watches a debounced loss-of-lock and the raw
// (synchronised) loss-of-signal, re-resetting the lane when either fails.
module cdr_reset_ctrl_mc #(
  parameter int NUM_CH     = 4,
  parameter int SHORT_CYC  = 32,
  parameter int LONG_CYC   = 4194304,
  parameter int TIMER_W    = 23,
  parameter int LOL_FILT   = 4,
  parameter int EARLY_LOCK = 0,
  parameter int RETRY_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cdr_reset_ctrl_mc_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_ASSRT      = 3'd0,
    ST_WAIT_SHORT = 3'd1,
    ST_WAIT_LONG  = 3'd2,
    ST_SEEK       = 3'd3,
    ST_WAIT_SIG   = 3'd4
  } state_t;

  localparam int                 FILT_W     = (LOL_FILT > 1) ? $clog2(LOL_FILT) : 1;
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOL_FILT - 1);
  localparam logic [TIMER_W-1:0] SHORT_LAST = TIMER_W'(SHORT_CYC - 1);
  localparam logic [TIMER_W-1:0] LONG_LAST  = TIMER_W'(LONG_CYC - 1);

  // Retry counters stick at all-ones so a flapping lane never wraps to a
  // misleadingly small count.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_CH-1:0] locked_v;
  logic [NUM_CH-1:0] rst_out_v;
  logic              all_locked_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    logic [1:0]         lol_sync;
    logic [1:0]         los_sync;
    logic               lol_f;
    logic [FILT_W-1:0]  flt_cnt;
    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retry;
    logic               locked;
    state_t             state;
    state_t             nxt;

    // Two-flop synchronisers; reset to "unlocked, no signal".
    always_ff @(posedge clk) begin
      if (rst) begin
        lol_sync <= 2'b11;
        los_sync <= 2'b11;
      end else begin
        lol_sync <= {lol_sync[0], bus.cdr_lol[g]};
        los_sync <= {los_sync[0], bus.cdr_los[g]};
      end
    end

    // Debounce loss-of-lock: accept a new level only after LOL_FILT
    // consecutive samples that disagree with the current filtered value.
    always_ff @(posedge clk) begin
      if (rst) begin
        lol_f   <= 1'b1;
        flt_cnt <= '0;
      end else if (lol_sync[1] == lol_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FILT_LAST) begin
        lol_f   <= lol_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end

    // Next-state decode; a forced restart overrides every other transition.
    always_comb begin
      nxt = state;
      case (state)
        ST_ASSRT:      nxt = ST_WAIT_SHORT;
        ST_WAIT_SHORT: if (timer == SHORT_LAST) nxt = ST_WAIT_LONG;
        ST_WAIT_LONG: begin
          if (los_sync[1])                      nxt = ST_WAIT_SIG;
          else if (timer == LONG_LAST)          nxt = ST_SEEK;
          else if ((EARLY_LOCK != 0) && !lol_f) nxt = ST_SEEK;
        end
        ST_SEEK: begin
          if (los_sync[1]) nxt = ST_WAIT_SIG;
          else if (lol_f)  nxt = ST_ASSRT;
        end
        ST_WAIT_SIG:   if (!los_sync[1]) nxt = ST_ASSRT;
        default:       nxt = ST_ASSRT;
      endcase
      if (bus.force_rst[g]) nxt = ST_ASSRT;
    end

    // Lane FSM, state timer, retry counter and registered lock flag.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= ST_ASSRT;
        timer  <= '0;
        retry  <= '0;
        locked <= 1'b0;
      end else begin
        state  <= nxt;
        timer  <= ((nxt != state) || (nxt == ST_ASSRT)) ? '0 : timer + 1'b1;
        if (bus.clr_retry)
          retry <= '0;
        else if (nxt == ST_ASSRT)
          retry <= sat_inc(retry);
        locked <= (state == ST_SEEK) && !lol_f;
      end
    end

    assign rst_out_v[g] = (state == ST_ASSRT) || (state == ST_WAIT_SHORT) ||
                          (state == ST_WAIT_SIG);
    assign locked_v[g]  = locked;
    assign bus.retry_cnt[g*RETRY_W +: RETRY_W] = retry;
  end

  // Whole-quad lock flag, one cycle behind the per-lane flags.
  always_ff @(posedge clk) begin
    if (rst) all_locked_r <= 1'b0;
    else     all_locked_r <= &locked_v;
  end

  assign bus.cdr_rst_out = rst_out_v;
  assign bus.lane_locked = locked_v;
  assign bus.all_locked  = all_locked_r;

endmodule

// File: tb/tb_cdr_reset_ctrl_mc.sv
// Bench for cdr_reset_ctrl_mc: two-lane instance with EARLY_LOCK=0 plus a
// second instance with EARLY_LOCK=1. Expected values are queued with their
// due cycle and compared as the run reaches that cycle.
module tb_cdr_reset_ctrl_mc;

  logic clk;
  logic rst;
  logic rst_e;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t  sb[$];
  string sig_name [8] = '{"cdr_rst_out", "lane_locked", "all_locked", "retry_cnt0",
                          "retry_cnt1", "early_cdr_rst_out", "early_lane_locked",
                          "early_all_locked"};

  cdr_reset_ctrl_mc_if #(.NUM_CH(2), .RETRY_W(8)) ifa ();
  cdr_reset_ctrl_mc_if #(.NUM_CH(2), .RETRY_W(8)) ifb ();

  cdr_reset_ctrl_mc #(
    .NUM_CH(2), .SHORT_CYC(4), .LONG_CYC(16), .TIMER_W(8),
    .LOL_FILT(3), .EARLY_LOCK(0), .RETRY_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  cdr_reset_ctrl_mc #(
    .NUM_CH(2), .SHORT_CYC(4), .LONG_CYC(16), .TIMER_W(8),
    .LOL_FILT(3), .EARLY_LOCK(1), .RETRY_W(8)
  ) dut_e (
    .clk (clk),
    .rst (rst_e),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Queue an expectation, kept ordered by due cycle.
  function automatic void push(int c, int s, logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.exp = v;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        sb.insert(i, e);
        return;
      end
    end
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] observe(int s);
    case (s)
      0:       return 32'(ifa.cdr_rst_out);
      1:       return 32'(ifa.lane_locked);
      2:       return 32'(ifa.all_locked);
      3:       return 32'(ifa.retry_cnt[7:0]);
      4:       return 32'(ifa.retry_cnt[15:8]);
      5:       return 32'(ifb.cdr_rst_out);
      6:       return 32'(ifb.lane_locked);
      7:       return 32'(ifb.all_locked);
      default: return 'x;
    endcase
  endfunction

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    int r;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    r = cyc;
    push(r, 0, 3); push(r, 1, 0); push(r, 2, 0); push(r, 3, 0); push(r, 4, 0);
    push(r + 4, 0, 3);  push(r + 5, 0, 0);
    push(r + 21, 0, 0); push(r + 21, 1, 0);
    push(r + 22, 1, 3); push(r + 22, 2, 0);
    push(r + 23, 2, 1); push(r + 23, 3, 0); push(r + 23, 4, 0);
    for (int i = 0; i <= 25; i++) begin
      if (i != 0) step();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL reset %s cyc=%0d got=%0h exp=%0h", sig_name[e.sig], e.cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_lol_filter();
    exp_t e;
    logic [31:0] obs;
    int b;
    int h;
    b = cyc;
    h = b + 12;
    push(b + 8, 0, 0); push(b + 8, 1, 3); push(b + 8, 3, 0);
    push(h + 5, 0, 0); push(h + 5, 1, 3);
    push(h + 6, 0, 1); push(h + 6, 1, 2); push(h + 6, 3, 1); push(h + 6, 4, 0);
    push(h + 7, 2, 0);
    push(h + 10, 0, 1); push(h + 11, 0, 0);
    push(h + 27, 1, 2); push(h + 28, 1, 3); push(h + 29, 2, 1);
    for (int i = 0; i <= 42; i++) begin
      if (i != 0) step();
      if (i == 0)  ifa.cdr_lol[0] = 1'b1;
      if (i == 2)  ifa.cdr_lol[0] = 1'b0;
      if (i == 12) ifa.cdr_lol[0] = 1'b1;
      if (i == 19) ifa.cdr_lol[0] = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL lol_filter %s cyc=%0d got=%0h exp=%0h", sig_name[e.sig], e.cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_los();
    exp_t e;
    logic [31:0] obs;
    int b;
    int l;
    b = cyc;
    l = b + 50;
    push(b + 2, 0, 0);
    push(b + 3, 0, 2); push(b + 3, 1, 3);
    push(b + 4, 1, 1); push(b + 4, 2, 1); push(b + 5, 2, 0);
    push(b + 25, 0, 2); push(b + 40, 1, 1);
    push(l + 2, 0, 2); push(l + 2, 4, 0);
    push(l + 3, 0, 2); push(l + 3, 4, 1);
    push(l + 7, 0, 2); push(l + 8, 0, 0);
    push(l + 24, 1, 1); push(l + 25, 1, 3); push(l + 26, 2, 1); push(l + 26, 3, 1);
    for (int i = 0; i <= 78; i++) begin
      if (i != 0) step();
      if (i == 0)  ifa.cdr_los[1] = 1'b1;
      if (i == 50) ifa.cdr_los[1] = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL los %s cyc=%0d got=%0h exp=%0h", sig_name[e.sig], e.cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_force();
    exp_t e;
    logic [31:0] obs;
    int b;
    b = cyc;
    push(b, 0, 0);
    push(b + 1, 0, 1); push(b + 1, 1, 3); push(b + 1, 3, 2);
    push(b + 2, 1, 2);
    push(b + 10, 0, 1); push(b + 10, 3, 11); push(b + 11, 3, 11);
    push(b + 14, 0, 1); push(b + 15, 0, 0);
    push(b + 263, 3, 254); push(b + 264, 3, 255);
    push(b + 320, 3, 255); push(b + 320, 4, 1);
    push(b + 321, 3, 0); push(b + 321, 4, 0); push(b + 323, 3, 0);
    push(b + 342, 1, 2); push(b + 343, 1, 3);
    for (int i = 0; i <= 345; i++) begin
      if (i != 0) step();
      if (i == 0)   ifa.force_rst[0] = 1'b1;
      if (i == 10)  ifa.force_rst[0] = 1'b0;
      if (i == 20)  ifa.force_rst[0] = 1'b1;
      if (i == 320) ifa.clr_retry = 1'b1;
      if (i == 321) begin
        ifa.force_rst[0] = 1'b0;
        ifa.clr_retry    = 1'b0;
      end
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL force %s cyc=%0d got=%0h exp=%0h", sig_name[e.sig], e.cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    logic [31:0] obs;
    int b;
    int r;
    b = cyc;
    r = b + 9;
    push(b + 8, 0, 0); push(b + 8, 1, 2); push(b + 8, 3, 1);
    push(r, 0, 3); push(r, 1, 0); push(r, 2, 0); push(r, 3, 0); push(r, 4, 0);
    push(r + 4, 0, 3); push(r + 5, 0, 0);
    push(r + 22, 1, 3); push(r + 23, 2, 1);
    for (int i = 0; i <= 34; i++) begin
      if (i != 0) step();
      if (i == 0) ifa.force_rst[0] = 1'b1;
      if (i == 1) ifa.force_rst[0] = 1'b0;
      if (i == 8) rst = 1'b1;
      if (i == 9) rst = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL rst_mid %s cyc=%0d got=%0h exp=%0h", sig_name[e.sig], e.cyc, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_early_lock();
    exp_t e;
    logic [31:0] obs;
    int r;
    r = cyc + 1;
    push(r, 5, 3); push(r, 6, 0);
    push(r + 4, 5, 3); push(r + 5, 5, 0);
    push(r + 6, 5, 0); push(r + 6, 6, 0);
    push(r + 7, 6, 3); push(r + 7, 7, 0); push(r + 8, 7, 1);
    for (int i = 0; i <= 10; i++) begin
      if (i != 0) step();
      if (i == 0) rst_e = 1'b1;
      if (i == 1) rst_e = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        obs = observe(e.sig);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL early_lock %s cyc=%0d got=%0h exp=%0h", sig_name[e.sig], e.cyc, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rst_e    = 1'b1;
    ifa.cdr_lol   = '0;
    ifa.cdr_los   = '0;
    ifa.force_rst = '0;
    ifa.clr_retry = 1'b0;
    ifb.cdr_lol   = '0;
    ifb.cdr_los   = '0;
    ifb.force_rst = '0;
    ifb.clr_retry = 1'b0;

    test_reset();
    test_lol_filter();
    test_los();
    test_force();
    test_rst_mid();
    test_early_lock();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdr_reset_ctrl_mc.md
Name: cdr_reset_ctrl_mc

Overview:
Multi-channel, parametrised CDR reset sequencer for the SERDES receive lanes. Each lane runs an independent FSM:
- pulses the CDR reset;
- waits a settle time;
- monitors a debounced loss-of-lock and loss-of-signal;
- re-resets the lane on failure.

It adds LOS hold-off, early-lock exit, a per-lane force request, saturating retry counters and lock status outputs. It sits between the SERDES quad status pins and the PCS reset logic, in the 125 MHz system clock domain.

Parameters:
NUM_CH, 4, number of independent lanes
SHORT_CYC, 32, cycles spent in WAIT_SHORT (reset assert width minus 1)
LONG_CYC, 4194304, cycles max in WAIT_LONG (~33.5 ms at 125 MHz)
TIMER_W, 23, per-lane timer width; must hold LONG_CYC-1 and SHORT_CYC-1
LOL_FILT, 4, consecutive synchronised cycles needed to accept a lol/lock level change (>=1)
EARLY_LOCK, 0, 1 = leave WAIT_LONG as soon as filtered lock is seen
RETRY_W, 8, width of each lane's retry counter

Ports:
clk  in  1  system clock, 125 MHz
rst  in  1  reset; one clock; reset is synchronous and active-high
cdr_lol  in  NUM_CH  async per-lane CDR loss-of-lock, 1 = unlocked
cdr_los  in  NUM_CH  async per-lane loss-of-signal, 1 = no signal
force_rst  in  NUM_CH  synchronous per-lane restart request, level, sampled each cycle
clr_retry  in  1  synchronous clear of all retry counters
cdr_rst_out  out  NUM_CH  per-lane CDR reset, 1 = reset
lane_locked  out  NUM_CH  per-lane lock status
all_locked  out  1  AND of lane_locked, registered
retry_cnt  out  NUM_CH*RETRY_W  packed per-lane retry counters, lane 0 in LSBs

Behaviour:
- Sync: cdr_lol and cdr_los pass through 2-flop synchronisers per lane; reset value 1 (unlocked, no signal).
- Lol filter per lane: a counter of consecutive identical synchronised samples, saturating at LOL_FILT.
  - lol_f changes to the sampled level only when LOL_FILT equal samples follow a change; reset value lol_f = 1.
  - LOS uses the synchronised level directly, no filter.
- Timer per lane: TIMER_W bits, cleared on every state entry, increments each cycle otherwise. The two wait conditions are mutually exclusive; if both would be true in the same cycle, the higher-priority rule listed first wins.
- States per lane (registered):
  - ASSRT:
    - 1 cycle;
    - clear timer;
    - retry_cnt +1 unless entry came from rst or clr_retry is active;
    - saturates at all-ones;
    - -> WAIT_SHORT.
  - WAIT_SHORT: when timer == SHORT_CYC-1, -> WAIT_LONG.
  - WAIT_LONG:
    - priority 1: los_sync=1 -> WAIT_SIG;
    - priority 2: timer == LONG_CYC-1 -> SEEK;
    - priority 3: EARLY_LOCK=1 and lol_f=0 -> SEEK.
  - SEEK:
    - priority 1: los_sync=1 -> WAIT_SIG;
    - priority 2: lol_f=1 -> ASSRT;
    - otherwise hold.
  - WAIT_SIG: hold until los_sync=0, then -> ASSRT.
- force_rst=1 in any state -> ASSRT next cycle. This has priority over all other transitions, and the retry count increments. While force_rst is held the lane re-enters ASSRT each cycle, so reset stays asserted.
- Outputs:
  - cdr_rst_out = 1 in ASSRT, WAIT_SHORT and WAIT_SIG; 0 in WAIT_LONG and SEEK. Decoded from the state register (no extra latency).
  - Minimum reset pulse = SHORT_CYC+1 cycles.
  - lane_locked = registered (state==SEEK and lol_f==0), so it is 1 cycle behind the state.
  - all_locked = registered AND of lane_locked, so it is 1 cycle behind lane_locked.
- Reset values:
  - every lane in ASSRT;
  - cdr_rst_out all 1s;
  - lane_locked and all_locked 0;
  - retry_cnt 0;
  - timers 0;
  - synchronisers and filters as above.
- rst mid-sequence: all lanes restart at ASSRT on the next cycle; retry_cnt is cleared, not incremented.
- clr_retry: clears all counters. If it coincides with an ASSRT increment, the clear wins and the result is 0.
- Lanes are fully independent; no shared timer.
- Any illegal state encoding -> ASSRT.

Test Plan:
Bench parameters: NUM_CH=2, SHORT_CYC=4, LONG_CYC=16, LOL_FILT=3.

1. Reset release, both lol=0, los=0, EARLY_LOCK=0 -> cdr_rst_out high for 5 cycles after rst falls, then low. lane_locked=1 at 5+16+1 cycles after release; all_locked=1 one cycle later; retry_cnt=0.
2. Locked lane 0, lol[0] pulsed high for 2 cycles -> no reset. Lol[0] held high for 3 or more cycles -> cdr_rst_out[0] rises 2+3+1 cycles after the edge and retry_cnt[0]=1. Lane 1 unaffected.
3. Locked lane 1, los[1]=1 for 50 cycles -> cdr_rst_out[1] high throughout and lane_locked[1]=0. After los falls plus sync delay -> ASSRT and a 5-cycle reset; retry_cnt[1]=1.
4. EARLY_LOCK=1, lol=0 during WAIT_LONG -> SEEK entered once lol_f is 0, well before 16 cycles; lane_locked=1 1 cycle later.
5. force_rst[0] held 10 cycles -> cdr_rst_out[0]=1 throughout plus 4 more cycles; retry_cnt[0] +10. Then 300 forced retries -> counter saturates at 255. clr_retry asserted in the same cycle as an increment -> 0.
6. rst asserted while lane 0 is in WAIT_LONG -> next cycle cdr_rst_out=all 1s, lane_locked=0, retry_cnt=0; the sequence of scenario 1 repeats.
